// File: rtl/cordic_vec.sv
// cordic_vec: iterative vectoring-mode CORDIC.
// Converts a Q2.16 Cartesian vector (x, y) into its angle atan2(y, x)
// (Q3.16 radians, saturated to +/-pi) and its magnitude (Q4.16, unsigned).
// One shared add/shift datapath performs ITER micro-rotations, one per clock.
//
// Build option:
//   CORDIC_VEC_GAIN_EN  defined   -> o_mag is compensated for the CORDIC gain
//                                    (x * 0.609375, same constant as the rotator)
//                       undefined -> o_mag is the raw x (gain ~1.6468)
module cordic_vec #(
  parameter int ITER = 16,  // micro-rotations, 1..16
  parameter int IW   = 20   // internal x/y width, >= 20
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic signed [17:0] i_x,
  input  logic signed [17:0] i_y,
  input  logic               i_req,
  output logic signed [18:0] o_theta,
  output logic        [19:0] o_mag,
  output logic               o_busy,
  output logic               o_ack
);

  // Angle accumulator width: pre-rotation (pi/2) plus the sum of the
  // arctan table (~1.74 rad) stays well inside 20-bit signed Q3.16.
  localparam int ZW = 20;

  localparam logic signed [ZW-1:0] PI_Q16      = 20'sd205887;
  localparam logic signed [ZW-1:0] NEG_PI_Q16  = -20'sd205887;
  localparam logic signed [ZW-1:0] HALF_PI_Q16 = 20'sd102944;
  localparam logic        [3:0]    LAST        = 4'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t                state;
  logic [3:0]            count;
  logic signed [IW-1:0]  x_r;
  logic signed [IW-1:0]  y_r;
  logic signed [ZW-1:0]  z_r;
  logic                  zero_r;

  logic signed [IW-1:0]  x_ext;
  logic signed [IW-1:0]  y_ext;
  logic signed [IW-1:0]  x0;
  logic signed [IW-1:0]  y0;
  logic signed [ZW-1:0]  z0;
  logic signed [IW-1:0]  x_sh;
  logic signed [IW-1:0]  y_sh;
  logic signed [18:0]    theta_sat;
  logic signed [IW-1:0]  mag_full;
  logic        [19:0]    mag_scaled;

  // Arctan table: round(atan(2^-i) * 2^16) in the rotator's radian scale.
  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 20'sd51472;
      4'd1:    atan_lut = 20'sd30386;
      4'd2:    atan_lut = 20'sd16055;
      4'd3:    atan_lut = 20'sd8150;
      4'd4:    atan_lut = 20'sd4091;
      4'd5:    atan_lut = 20'sd2047;
      4'd6:    atan_lut = 20'sd1024;
      4'd7:    atan_lut = 20'sd512;
      4'd8:    atan_lut = 20'sd256;
      4'd9:    atan_lut = 20'sd128;
      4'd10:   atan_lut = 20'sd64;
      4'd11:   atan_lut = 20'sd32;
      4'd12:   atan_lut = 20'sd16;
      4'd13:   atan_lut = 20'sd8;
      4'd14:   atan_lut = 20'sd4;
      default: atan_lut = 20'sd2;
    endcase
  endfunction

  // Quadrant pre-rotation: fold left-half-plane inputs into x >= 0 so the
  // micro-rotations only have to cover +/-pi/2. IW is wide enough that
  // negating -131072 cannot overflow.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    x_ext = {{(IW-18){i_x[17]}}, i_x};
    y_ext = {{(IW-18){i_y[17]}}, i_y};
    x0    = x_ext;
    y0    = y_ext;
    z0    = '0;
    if (i_x[17]) begin
      if (!i_y[17]) begin
        x0 = y_ext;
        y0 = -x_ext;
        z0 = HALF_PI_Q16;
      end else begin
        x0 = -y_ext;
        y0 = x_ext;
        z0 = -HALF_PI_Q16;
      end
    end
  end

  // Shared shifter: arithmetic shifts by the current iteration index.
  always_comb begin
    x_sh = x_r >>> count;
    y_sh = y_r >>> count;
  end

  // Clamp the accumulated angle to +/-pi before it leaves the block.
  always_comb begin
    theta_sat = z_r[18:0];
    if (z_r > PI_Q16) begin
      theta_sat = PI_Q16[18:0];
    end else if (z_r < NEG_PI_Q16) begin
      theta_sat = NEG_PI_Q16[18:0];
    end
  end

`ifdef CORDIC_VEC_GAIN_EN
  // Gain compensation: x * (1/2 + 1/16 + 1/32 + 1/64) = x * 0.609375.
  assign mag_full = (x_r >>> 1) + (x_r >>> 4) + (x_r >>> 5) + (x_r >>> 6);
`else
  // Raw magnitude carrying the CORDIC gain; fine for relative comparisons.
  assign mag_full = x_r;
`endif

  assign mag_scaled = mag_full[19:0];

  // Control FSM and datapath: capture, ITER micro-rotations, then publish.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    // NOTE: the datapath registers are reset along with the control state, so
    // a reset mid-conversion leaves no stale vector behind.
    if (!i_nrst) begin
      state   <= S_IDLE;
      count   <= '0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      zero_r  <= 1'b0;
      o_theta <= '0;
      o_mag   <= '0;
      o_busy  <= 1'b0;
      o_ack   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so x and y both update from their
      // pre-edge values exactly as the micro-rotation equations require.
      o_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            x_r    <= x0;
            y_r    <= y0;
            z_r    <= z0;
            zero_r <= (i_x == '0) && (i_y == '0);
            count  <= '0;
            o_busy <= 1'b1;
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          if (y_r[IW-1]) begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_lut(count);
          end else begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_lut(count);
          end
          count <= count + 4'd1;
          if (count == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          o_theta <= zero_r ? '0 : theta_sat;
          o_mag   <= zero_r ? '0 : mag_scaled;
          o_ack   <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec.sv
// tb_cordic_vec: directed self-checking bench for cordic_vec.
// Expected magnitudes follow the CORDIC_VEC_GAIN_EN build option.
module tb_cordic_vec;

  logic               i_clk  = 1'b0;
  logic               i_nrst = 1'b0;
  logic               i_req  = 1'b0;
  logic signed [17:0] i_x    = '0;
  logic signed [17:0] i_y    = '0;
  logic signed [18:0] o_theta;
  logic        [19:0] o_mag;
  logic               o_busy;
  logic               o_ack;

  int checks   = 0;
  int failures = 0;

`ifdef CORDIC_VEC_GAIN_EN
  localparam int MAG_UNIT = 65764;   // |(65535,0)| compensated
  localparam int MAG_DIAG = 65765;   // |(-46341,-46341)| compensated
  localparam int MAG_TOL  = 16;
  localparam int MAG_BIG  = 186013;  // |(-131072,-131072)| compensated
`else
  localparam int MAG_UNIT = 107921;
  localparam int MAG_DIAG = 107921;
  localparam int MAG_TOL  = 24;
  localparam int MAG_BIG  = 305253;
`endif

  always #5 i_clk = ~i_clk;

  cordic_vec dut (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_req   (i_req),
    .o_theta (o_theta),
    .o_mag   (o_mag),
    .o_busy  (o_busy),
    .o_ack   (o_ack)
  );

  // Compare observed against expected within +/-tol.
  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= tol) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Issue one request, optionally pulse i_req with other inputs before
  // edges pa and pb, then watch a bounded window of edges for o_ack.
  task automatic run(input int x, input int y, input int pa, input int pb,
                     output int lat, output int acks, output int busy_at_ack);
    @(negedge i_clk);
    i_x   = 18'(x);
    i_y   = 18'(y);
    i_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    check("busy_after_accept", int'(o_busy), 1, 0);
    lat         = -1;
    acks        = 0;
    busy_at_ack = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge i_clk);
      if (c == pa || c == pb) begin
        i_req = 1'b1;
        i_x   = 18'sd1000;
        i_y   = -18'sd70000;
      end else begin
        i_req = 1'b0;
      end
      @(posedge i_clk);
      #1;
      if (o_ack) begin
        acks++;
        if (lat < 0) begin
          lat         = c;
          busy_at_ack = int'(o_busy);
        end
      end
    end
    i_req = 1'b0;
  endtask

  initial begin
    int lat, acks, bsy, first, second;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_theta", int'(o_theta), 0, 0);
    check("rst_mag",   int'(o_mag),   0, 0);
    check("rst_busy",  int'(o_busy),  0, 0);
    check("rst_ack",   int'(o_ack),   0, 0);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // (65535, 0): angle 0, latency and pulse width
    run(65535, 0, 0, 0, lat, acks, bsy);
    check("unit_lat",   lat,  17, 0);
    check("unit_acks",  acks, 1,  0);
    check("unit_busy",  bsy,  0,  0);
    check("unit_theta", int'(o_theta), 0, 4);
    check("unit_mag",   int'(o_mag), MAG_UNIT, MAG_TOL);

    // (0, 65535): +pi/2
    run(0, 65535, 0, 0, lat, acks, bsy);
    check("y_axis_theta", int'(o_theta), 102944, 4);

    // (-65535, 0): +pi, positive sign
    run(-65535, 0, 0, 0, lat, acks, bsy);
    check("neg_x_theta", int'(o_theta), 205887, 4);

    // (-46341, -46341): -3pi/4
    run(-46341, -46341, 0, 0, lat, acks, bsy);
    check("diag_theta", int'(o_theta), -154415, 4);
    check("diag_mag",   int'(o_mag), MAG_DIAG, MAG_TOL);

    // Zero vector
    run(0, 0, 0, 0, lat, acks, bsy);
    check("zero_lat",   lat, 17, 0);
    check("zero_theta", int'(o_theta), 0, 0);
    check("zero_mag",   int'(o_mag),   0, 0);

    // Full-scale negative on both axes
    run(-131072, -131072, 0, 0, lat, acks, bsy);
    check("full_theta", int'(o_theta), -154415, 4);
    check("full_mag",   int'(o_mag), MAG_BIG, 100);

    // Requests at cycles 3 and 10 are ignored
    run(0, 65535, 3, 10, lat, acks, bsy);
    check("ignore_lat",   lat,  17, 0);
    check("ignore_acks",  acks, 1,  0);
    check("ignore_theta", int'(o_theta), 102944, 4);

    // Reset at cycle 8 of a conversion
    @(negedge i_clk);
    i_x   = -18'sd46341;
    i_y   = 18'sd46341;
    i_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    repeat (7) @(posedge i_clk);
    @(negedge i_clk);
    i_nrst = 1'b0;
    #1;
    check("midrst_busy",  int'(o_busy),  0, 0);
    check("midrst_ack",   int'(o_ack),   0, 0);
    check("midrst_theta", int'(o_theta), 0, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_nrst = 1'b1;
    acks = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge i_clk);
      #1;
      if (o_ack) acks++;
    end
    check("midrst_no_ack", acks, 0, 0);

    // Fresh request after reset: +3pi/4
    run(-46341, 46341, 0, 0, lat, acks, bsy);
    check("post_rst_lat",   lat, 17, 0);
    check("post_rst_theta", int'(o_theta), 154415, 4);

    // i_req held high: back-to-back conversions every ITER+2 cycles
    @(negedge i_clk);
    i_x   = 18'sd65535;
    i_y   = 18'sd0;
    i_req = 1'b1;
    first  = -1;
    second = -1;
    for (int c = 0; c <= 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_ack) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    i_req = 1'b0;
    check("held_first_ack",  first,  17, 0);
    check("held_second_ack", second, 35, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
